// File: rtl/dmem_lsu.sv
// dmem_lsu: Memory-stage load/store unit.
// Converts M-stage loads/stores into valid/ready bus transactions, steers
// store bytes onto lanes, extracts and extends load data, and holds the
// pipeline through lsu_stall until the access completes.
// Build option: DMEM_MISALIGN_TRAP_EN traps misaligned H/W accesses
// (no bus request, bus_err pulse in DONE) instead of dropping the low bits.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no access in flight; an M-stage access latches and moves on
// REQ      | request presented on the bus, held until req_ready
// WAIT_RSP | load accepted, waiting for rsp_valid or timeout
// DONE     | single cycle with lsu_stall low so the pipeline advances

module dmem_lsu #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        lsu_stall,
    output logic        bus_err,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_we,
    output logic [31:0] req_addr,
    output logic [3:0]  req_be,
    output logic [31:0] req_wdata,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_rdata
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RSP,
        S_DONE
    } state_t;

    state_t        state, state_d;
    logic [31:0]   addr_q;
    logic [2:0]    f3_q;
    logic          we_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          access;
    logic [3:0]    be_in;
    logic [31:0]   wdata_in;
    logic          capture;
    logic          set_err;
    logic          clr_rdata;

    // Lane extraction and sign/zero extension of a returned read word.
    function automatic logic [31:0] load_ext(input logic [2:0] f3,
                                             input logic [1:0] a,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3[1:0])
            2'b00:   load_ext = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   load_ext = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: load_ext = w;
        endcase
    endfunction

    assign access = MemReadM | MemWriteM;

    // Byte enables and lane-replicated store data from the incoming access.
    always_comb begin
        be_in    = 4'b1111;
        wdata_in = WriteDataM;
        case (funct3M[1:0])
            2'b00: begin
                be_in    = 4'b0001 << ALUResultM[1:0];
                wdata_in = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be_in    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{WriteDataM[15:0]}};
            end
            default: begin
                be_in    = 4'b1111;
                wdata_in = WriteDataM;
            end
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misalign;

    // Halfword needs a[0]=0, word needs a[1:0]=0; reserved codes behave as word.
    always_comb begin
        case (funct3M[1:0])
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = ALUResultM[0];
            default: misalign = |ALUResultM[1:0];
        endcase
    end
`endif

    // Next-state, stall and request-valid decode.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt_q;
        lsu_stall = 1'b0;
        req_valid = 1'b0;
        capture   = 1'b0;
        set_err   = 1'b0;
        clr_rdata = 1'b0;
        case (state)
            S_IDLE: begin
                if (access) begin
                    lsu_stall = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
                    if (misalign) begin
                        state_d   = S_DONE;
                        set_err   = 1'b1;
                        clr_rdata = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ: begin
                lsu_stall = 1'b1;
                req_valid = 1'b1;
                if (req_ready) begin
                    if (we_q) begin
                        state_d = S_DONE;
                    end else if (rsp_valid) begin
                        capture = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = TMO_LOAD;
                        state_d = S_WAIT_RSP;
                    end
                end
            end
            S_WAIT_RSP: begin
                lsu_stall = 1'b1;
                if (rsp_valid) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == '0) begin
                    set_err   = 1'b1;
                    clr_rdata = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, timeout counter, latched request fields and load result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_d;
            cnt_q <= cnt_d;
            err_q <= set_err;
            if (state == S_IDLE && access) begin
                addr_q  <= ALUResultM;
                f3_q    <= funct3M;
                we_q    <= MemWriteM;
                be_q    <= be_in;
                wdata_q <= wdata_in;
            end
            if (capture) begin
                rdata_q <= load_ext(f3_q, addr_q[1:0], rsp_rdata);
            end else if (clr_rdata) begin
                rdata_q <= '0;
            end
        end
    end

    assign req_we    = we_q;
    assign req_addr  = {addr_q[31:2], 2'b00};
    assign req_be    = be_q;
    assign req_wdata = wdata_q;
    assign ReadDataM = rdata_q;
    assign bus_err   = err_q;

endmodule
